// File: rtl/bcast_fork.sv
// bcast_fork: broadcast fork. One word taken on a valid/ready input is held
// and offered to IN output lanes, each with its own valid/ready handshake.
// The next word is taken only once every targeted lane has accepted the
// held one.
// Optional feature: define BCAST_FORK_MASK_EN to add the in_mask port, which
// selects the target lanes for each accepted word. With the macro undefined,
// every accepted word targets all lanes.
module bcast_fork #(
    parameter int IN   = 4,
    parameter int DATA = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA-1:0]          in_data,
`ifdef BCAST_FORK_MASK_EN
    input  logic [IN-1:0]            in_mask,
`endif
    output logic [IN-1:0]            out_valid,
    input  logic [IN-1:0]            out_ready,
    output logic [IN-1:0][DATA-1:0]  out_data,
    output logic                     done,
    output logic                     busy
);

    logic [DATA-1:0] data_r;
    logic [IN-1:0]   pend;
    logic [IN-1:0]   owe;
    logic [IN-1:0]   tgt;
    logic            accept;

    // Lanes still pending after this cycle's handshakes. in_ready depends
    // combinationally on out_ready so that a word can be replaced in the
    // same cycle its last lane accepts it.
    always_comb begin
        owe      = pend & ~out_ready;
        in_ready = ~|owe;
        accept   = in_valid & in_ready;
`ifdef BCAST_FORK_MASK_EN
        tgt      = in_mask;
`else
        tgt      = '1;
`endif
    end

    // Every lane carries the same held word; valid is the pending set.
    always_comb begin
        out_valid = pend;
        busy      = |pend;
        for (int i = 0; i < IN; i++) begin
            out_data[i] = data_r;
        end
    end

    // Hold the word and pending set; a new accept overrides lane clearing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= '0;
            pend   <= '0;
            done   <= 1'b0;
        end else begin
            done <= (|pend) & ~(|owe);
            if (accept) begin
                data_r <= in_data;
                pend   <= tgt;
            end else begin
                pend <= owe;
            end
        end
    end

endmodule

// File: doc/bcast_fork.md
# bcast_fork

Parameterized broadcast fork: accepts one DATA word on a valid/ready input and delivers it to IN output lanes, each with its own valid/ready handshake. The word is held until every targeted lane has accepted it. This is the fan-out counterpart of the reduction tree: `reduct` combines IN operands into one result, and `bcast_fork` distributes one operand to IN consumers. Typical use is feeding a shared operand or command to parallel units whose results are later recombined by `reduct`.

## Interface
- `IN`, 4: number of output lanes, ≥1.
- `DATA`, 16: data width in bits.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word offered.
- `in_ready`  out  1  input word accepted this cycle when high with `in_valid`.
- `in_data`  in  DATA  input word.
- `in_mask`  in  IN  target lanes for the offered word; present only with `BCAST_FORK_MASK_EN`.
- `out_valid`  out  IN  per-lane valid; bit i belongs to lane i.
- `out_ready`  in  IN  per-lane ready.
- `out_data`  out  [IN-1:0][DATA-1:0]  per-lane data; every lane carries the same held word.
- `done`  out  1  one-cycle pulse when the last pending lane of a word accepts it.
- `busy`  out  1  high while any lane is pending.

## Operation
- State:
  - `data_r[DATA-1:0]`: held word.
  - `pend[IN-1:0]`: lanes that still owe an acceptance.
- Outputs are driven from state:
  - `out_valid = pend`.
  - Each `out_data[i] = data_r`.
  - `busy = |pend`.
- Lane i handshake: completes in any cycle with `pend[i] & out_ready[i]`. Bit `pend[i]` clears at the next edge.
- `in_ready = ~|(pend & ~out_ready)`. It is high when nothing is pending, or when every still-pending lane accepts this cycle. This gives full throughput: one word per cycle when all lanes are always ready. The path from `out_ready` to `in_ready` is combinational by design.
- Input accept (`in_valid & in_ready`):
  - `data_r <= in_data`.
  - `pend <= tgt`, where `tgt` is all-ones, or `in_mask` with the macro enabled.
  - Overrides the clearing of `pend` in the same cycle; the old word is fully consumed by construction.
- No accept: `pend <= pend & ~out_ready`. `data_r` holds.
- `done`: registered. Asserted for the cycle after the edge at which a non-zero `pend` becomes zero, or at which it is reloaded while every old pending lane accepted.
  - Equivalently, `done` asserts at edge t+1 iff at cycle t `(pend != 0) && ((pend & ~out_ready) == 0)`.
- Lanes are independent. A lane may accept in the cycle its valid rises, or any later cycle. Lanes never receive the same word twice.
- `out_ready[i]` while `pend[i]` is low has no effect.
- `in_valid` low: no state change except lane clearing.

## Timing
- Reset values: `pend = 0`, `data_r = 0`, `done = 0`. Therefore `out_valid = 0`, `out_data = 0`, `busy = 0`, and `in_ready = 1`.
- Latency: a word accepted at edge t appears on all targeted `out_valid`/`out_data` at cycle t+1.
- Best case: lane acceptance in cycle t+1, next word accepted in the same cycle, `done` at cycle t+2.
- Stall: a lane holding `out_ready` low keeps `in_ready` low indefinitely. Other lanes that already accepted stay deasserted.
- `reset` mid-transfer discards the held word and all pending lanes immediately (asynchronously). No `done` is produced for it.
- `IN = 1` degenerates to a single-entry pipeline register with valid/ready.

## Configuration
- `BCAST_FORK_MASK_EN` defined:
  - The `in_mask` port exists, and `pend` loads `in_mask` on accept.
  - A word accepted with `in_mask = 0` is consumed and dropped: `pend` stays 0, no lane is valid, and no `done` is produced.
- Not defined: there is no `in_mask` port; every accepted word targets all IN lanes.

## Test plan
- Reset check: assert `reset` asynchronously mid-cycle → `out_valid = 0`, `out_data = 0`, `busy = 0`, `done = 0`, `in_ready = 1` immediately.
- All lanes ready, IN=4: stream 0x0001..0x0008 with `in_valid` held high → one accept per cycle, each word on all 4 lanes one cycle later, `done` every cycle from cycle 2.
- Staggered accepts: word 0xA5A5, `out_ready` = 0001, then 0100, then 1010 on successive cycles → `out_valid` = 1111→1110→1010→0000, `in_ready` low until the third cycle, single `done` pulse after.
- Stuck lane: lane 3 `out_ready = 0` for 10 cycles while `in_valid = 1` → `in_ready = 0`, `out_valid = 1000`, `data_r` unchanged. Release lane 3 → next word accepted in the same cycle.
- Reset mid-transfer: `pend = 0110`, assert `reset` → `out_valid = 0000` immediately, no `done`. After release, a new word 0x1234 is accepted normally.
- With `BCAST_FORK_MASK_EN`:
  - Word 0xBEEF, `in_mask = 0101` → only lanes 0 and 2 are valid, and `done` pulses after both accept.
  - `in_mask = 0000` → `in_ready` stays 1, no `out_valid`, no `done`.
